// File: rtl/seq_rec_pkg.sv
// Shared constants and helpers for the parametrised serial sequence recognizer.
package seq_rec_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  // Values of the OVERLAP input.
  localparam logic OVERLAP_ON  = 1'b1;
  localparam logic OVERLAP_OFF = 1'b0;

  // Width of the fill counter, which has to hold the values 0..pat_len.
  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// CLR beats a same-edge INC. SAT is registered from the next-state count,
// so it rises together with COUNT reaching all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] COUNT,
  output logic         SAT
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] count_d;

  // Next count: clear first, otherwise increment unless already at the ceiling.
  always_comb begin
    count_d = COUNT;
    if (CLR) begin
      count_d = '0;
    end else if (INC && (COUNT != CNT_MAX)) begin
      count_d = COUNT + W'(1);
    end
  end

  // Count and saturation flag registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      COUNT <= '0;
      SAT   <= 1'b0;
    end else begin
      COUNT <= count_d;
      SAT   <= (count_d == CNT_MAX);
    end
  end

endmodule

// File: rtl/seq_rec_param.sv
// Serial sequence recognizer: shifts X into a history register on every
// enabled edge and compares the newest PAT_LEN bits against a loadable
// pattern under a per-bit care mask. Z is a registered one-cycle pulse per
// match; MATCH_CNT counts matches and saturates.
module seq_rec_param
  import seq_rec_pkg::*;
#(
  parameter int                 PAT_LEN  = 4,
  parameter int                 CNT_W    = 8,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1101
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               EN,
  input  logic               X,
  input  logic               LOAD,
  input  logic [PAT_LEN-1:0] PAT_IN,
  input  logic [PAT_LEN-1:0] MASK_IN,
  input  logic               OVERLAP,
  input  logic               CLR_CNT,
  output logic               Z,
  output logic [CNT_W-1:0]   MATCH_CNT,
  output logic               CNT_SAT
);

  localparam int             FW        = fill_width(PAT_LEN);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_LEN);

  if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_pat_len
    $error("seq_rec_param: PAT_LEN=%0d is outside %0d..%0d", PAT_LEN, PAT_LEN_MIN, PAT_LEN_MAX);
  end

  // Pattern, mask and history; the newest received bit lives in hist[0],
  // so the first pattern bit lines up with PAT_IN's MSB.
  logic [PAT_LEN-1:0] pat, pat_d;
  logic [PAT_LEN-1:0] mask, mask_d;
  logic [PAT_LEN-1:0] hist, hist_d, hist_shift;
  logic [FW-1:0]      fill, fill_d, fill_inc;
  logic               match;

  // Next-state for pattern/history/fill and the match decision.
  // LOAD discards the same-cycle sample; a non-overlapping match empties
  // fill so the stale history bits cannot contribute to the next match.
  always_comb begin
    hist_shift = {hist[PAT_LEN-2:0], X};
    fill_inc   = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
    pat_d      = pat;
    mask_d     = mask;
    hist_d     = hist;
    fill_d     = fill;
    match      = 1'b0;
    if (LOAD) begin
      pat_d  = PAT_IN;
      mask_d = MASK_IN;
      fill_d = '0;
    end else if (EN) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      match  = (fill_inc == FILL_FULL) && (((hist_shift ^ pat) & mask) == '0);
      if (match && (OVERLAP == OVERLAP_OFF)) begin
        fill_d = '0;
      end
    end
  end

  // Pattern/history registers and the registered match pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pat  <= PAT_INIT;
      mask <= '1;
      hist <= '0;
      fill <= '0;
      Z    <= 1'b0;
    end else begin
      pat  <= pat_d;
      mask <= mask_d;
      hist <= hist_d;
      fill <= fill_d;
      Z    <= match;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .CLK  (CLK),
    .RESET(RESET),
    .CLR  (CLR_CNT),
    .INC  (match),
    .COUNT(MATCH_CNT),
    .SAT  (CNT_SAT)
  );

endmodule
